// File: rtl/cameralink_frame_capture.sv
// rtl/cameralink_frame_capture.sv - CameraLink frame capture with SOF/EOL tagging, output FIFO and geometry
//
// Purpose:
//   Capture stage on the CameraLink pixel clock. An arm request waits for a
//   clean frame start (FVV low, then rising). Qualified pixels (FVV&LVV&VCE)
//   pass through a one-pixel hold register so the last pixel of each line can
//   be tagged EOL when LVV (or FVV) falls. Tagged pixels are buffered in a
//   small FIFO drained over a valid/ready stream. Line width (first line) and
//   frame height are measured per frame; a full FIFO drops pixels and sets a
//   sticky overflow flag.
//
// Optional feature macro: CAMERALINK_CAPTURE_GEOMETRY_CHECK_EN
//   Adds sticky geom_err, set when any line's pixel count differs from the
//   first line of the same frame; cleared by arm.
//
// Ports:
//   clock, reset                 pixel clock, synchronous active-high reset
//   FVV, LVV, VCE                frame valid, line valid, pixel enable
//   red, green, blue             pixel components
//   arm                          request capture of the next full frame
//   cam_enable, busy             high while armed or capturing
//   out_valid/out_ready          output stream handshake
//   out_data, out_sof, out_eol   {blue,green,red} and markers of the FIFO head
//   line_width, frame_height     geometry of the last captured frame
//   done                         one-cycle pulse at frame completion
//   overflow                     sticky, a pixel was dropped on a full FIFO
//   geom_err                     (macro only) sticky line-width mismatch

module cameralink_frame_capture #(
  parameter int FIFO_DEPTH = 16,
  parameter int COUNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               FVV,
  input  logic               LVV,
  input  logic               VCE,
  input  logic [7:0]         red,
  input  logic [7:0]         green,
  input  logic [7:0]         blue,
  input  logic               arm,
  output logic               cam_enable,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [23:0]        out_data,
  output logic               out_sof,
  output logic               out_eol,
  output logic [COUNT_W-1:0] line_width,
  output logic [COUNT_W-1:0] frame_height,
  output logic               done,
  output logic               overflow
`ifdef CAMERALINK_CAPTURE_GEOMETRY_CHECK_EN
  ,
  output logic               geom_err
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_SYNC    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               prev_lvv_q;
  logic               hold_full_q, hold_full_d;
  logic [23:0]        hold_data_q, hold_data_d;
  logic               hold_sof_q, hold_sof_d;
  logic               sof_pend_q, sof_pend_d;
  logic [COUNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [COUNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [COUNT_W-1:0] first_w_q, first_w_d;
  logic [COUNT_W-1:0] line_width_q, line_width_d;
  logic [COUNT_W-1:0] frame_height_q, frame_height_d;
  logic               done_q;
  logic               overflow_q, overflow_d;

  logic [25:0]        fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic [25:0]        head;

  logic arm_accept;
  logic in_cap;
  logic pix_qual;
  logic line_end;
  logic line_closed;
  logic frame_end;
  logic push_req;
  logic push_ok;
  logic pop;
  logic drop;
  logic [25:0] push_entry;

  // SYNC with FVV high is the first capture cycle, so it qualifies pixels too.
  assign arm_accept  = (state_q == S_IDLE) & arm;
  assign in_cap      = (state_q == S_CAPTURE) | ((state_q == S_SYNC) & FVV);
  assign pix_qual    = in_cap & FVV & LVV & VCE;
  // FVV low in CAPTURE also closes a truncated line; it never coincides with
  // a qualified pixel because both require opposite levels of LVV or FVV.
  assign line_end    = (state_q == S_CAPTURE) & ((prev_lvv_q & ~LVV) | ~FVV);
  assign line_closed = line_end & (pix_cnt_q != '0);
  assign frame_end   = (state_q == S_CAPTURE) & ~FVV;

  assign push_req   = hold_full_q & (pix_qual | line_end);
  assign push_entry = {hold_sof_q, line_end, hold_data_q};

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = push_req & ((count_q != DEPTH_C) | pop);
  assign drop      = push_req & ~push_ok;

  assign head     = fifo_mem[rd_ptr_q];
  assign out_data = out_valid ? head[23:0] : 24'd0;
  assign out_eol  = out_valid & head[24];
  assign out_sof  = out_valid & head[25];

  assign cam_enable   = (state_q != S_IDLE);
  assign busy         = cam_enable;
  assign line_width   = line_width_q;
  assign frame_height = frame_height_q;
  assign done         = done_q;
  assign overflow     = overflow_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (arm)  state_d = S_ARMED;
      S_ARMED:   if (!FVV) state_d = S_SYNC;
      S_SYNC:    if (FVV)  state_d = S_CAPTURE;
      S_CAPTURE: if (!FVV) state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_full_d    = hold_full_q;
    hold_data_d    = hold_data_q;
    hold_sof_d     = hold_sof_q;
    sof_pend_d     = sof_pend_q;
    pix_cnt_d      = pix_cnt_q;
    line_cnt_d     = line_cnt_q;
    first_w_d      = first_w_q;
    line_width_d   = line_width_q;
    frame_height_d = frame_height_q;
    overflow_d     = overflow_q | drop;

    if (arm_accept) begin
      hold_full_d = 1'b0;
      sof_pend_d  = 1'b1;
      pix_cnt_d   = '0;
      line_cnt_d  = '0;
      first_w_d   = '0;
      overflow_d  = 1'b0;
    end else begin
      if (pix_qual) begin
        hold_full_d = 1'b1;
        hold_data_d = {blue, green, red};
        hold_sof_d  = sof_pend_q;
        sof_pend_d  = 1'b0;
        if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 1'b1;
      end else if (line_end) begin
        hold_full_d = 1'b0;
        pix_cnt_d   = '0;
        if (line_closed) begin
          if (line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_q == '0)      first_w_d  = pix_cnt_q;
        end
      end
      // Geometry publishes the frame's totals including the line closed now.
      if (frame_end) begin
        line_width_d   = first_w_d;
        frame_height_d = line_cnt_d;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      prev_lvv_q     <= 1'b0;
      hold_full_q    <= 1'b0;
      hold_data_q    <= '0;
      hold_sof_q     <= 1'b0;
      sof_pend_q     <= 1'b0;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      first_w_q      <= '0;
      line_width_q   <= '0;
      frame_height_q <= '0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_lvv_q     <= LVV;
      hold_full_q    <= hold_full_d;
      hold_data_q    <= hold_data_d;
      hold_sof_q     <= hold_sof_d;
      sof_pend_q     <= sof_pend_d;
      pix_cnt_q      <= pix_cnt_d;
      line_cnt_q     <= line_cnt_d;
      first_w_q      <= first_w_d;
      line_width_q   <= line_width_d;
      frame_height_q <= frame_height_d;
      done_q         <= frame_end;
      overflow_q     <= overflow_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef CAMERALINK_CAPTURE_GEOMETRY_CHECK_EN
  logic geom_err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      geom_err_q <= 1'b0;
    end else if (arm_accept) begin
      geom_err_q <= 1'b0;
    end else if (line_closed && (line_cnt_q != '0) && (pix_cnt_q != first_w_q)) begin
      geom_err_q <= 1'b1;
    end
  end

  assign geom_err = geom_err_q;
`endif

endmodule

// File: tb/tb_cameralink_frame_capture.sv
// tb/tb_cameralink_frame_capture.sv - self-checking bench for cameralink_frame_capture
module tb_cameralink_frame_capture;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [23:0] data;
  } pix_t;

  typedef struct {
    int lines;
    int cyc;
    int mode;
    int ew;
    int eh;
    int ep;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        FVV, LVV, VCE;
  logic [7:0]  red, green, blue;
  logic        arm;
  logic        cam_enable, busy;
  logic        out_valid, out_ready;
  logic [23:0] out_data;
  logic        out_sof, out_eol;
  logic [15:0] line_width, frame_height;
  logic        done, overflow;
`ifdef CAMERALINK_CAPTURE_GEOMETRY_CHECK_EN
  logic        geom_err;
`endif

  always #5 clk = ~clk;

  cameralink_frame_capture #(.FIFO_DEPTH(16), .COUNT_W(16)) dut (
    .clock(clk), .reset(reset), .FVV(FVV), .LVV(LVV), .VCE(VCE),
    .red(red), .green(green), .blue(blue), .arm(arm),
    .cam_enable(cam_enable), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol),
    .line_width(line_width), .frame_height(frame_height),
    .done(done), .overflow(overflow)
`ifdef CAMERALINK_CAPTURE_GEOMETRY_CHECK_EN
    , .geom_err(geom_err)
`endif
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  pix_t exp_q[$];
  pix_t rx_q[$];
  int   line_pix[$];
  bit   exp_sof_pend;
  bit   rand_ready;
  int   done_cnt;
  logic [15:0] done_lw, done_fh;
  logic done_busy;
  bit   stall;
  pix_t held;
  vec_t tbl[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output observation happens at the negedge, inside the single stimulus process.
  task automatic sample();
    if (reset) begin
      stall = 1'b0;
    end else begin
      if (stall && out_valid) check("head_stable", {out_sof, out_eol, out_data}, held);
      if (out_valid && out_ready) rx_q.push_back({out_sof, out_eol, out_data});
      if (done) begin
        done_cnt++;
        done_lw   = line_width;
        done_fh   = frame_height;
        done_busy = busy;
      end
      stall = out_valid && !out_ready;
      held  = {out_sof, out_eol, out_data};
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_model();
    exp_q.delete();
    rx_q.delete();
    line_pix.delete();
    done_cnt = 0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    exp_sof_pend = 1'b1;
    check("busy_after_arm", busy, 1);
    check("cam_en_after_arm", cam_enable, 1);
    step();
  endtask

  // mode 0: VCE always 1; mode 1: 1,0,1,0...; mode 2: random with first cycle 1
  task automatic drive_line(input int cyc, input int mode, input bit rec);
    int cnt = 0;
    int last = -1;
    for (int c = 0; c < cyc; c++) begin
      logic v;
      case (mode)
        0:       v = 1'b1;
        1:       v = ((c % 2) == 0);
        default: v = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      LVV   = 1'b1;
      VCE   = v;
      red   = 8'($urandom);
      green = 8'($urandom);
      blue  = 8'($urandom);
      if (rec && v) begin
        pix_t p;
        p.data = {blue, green, red};
        p.sof  = exp_sof_pend;
        p.eol  = 1'b0;
        exp_sof_pend = 1'b0;
        exp_q.push_back(p);
        last = exp_q.size() - 1;
        cnt++;
      end
      step();
    end
    LVV = 1'b0;
    VCE = 1'b0;
    if (rec) begin
      if (last >= 0) exp_q[last].eol = 1'b1;
      line_pix.push_back(cnt);
    end
    step();
    step();
  endtask

  task automatic drive_frame(input int lines, input int cyc, input int mode, input bit rec);
    FVV = 1'b1;
    LVV = 1'b0;
    step();
    for (int l = 0; l < lines; l++) drive_line(cyc, mode, rec);
    FVV = 1'b0;
    step();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && done_cnt == 0; i++) step();
  endtask

  task automatic drain(input int n);
    rand_ready = 1'b1;
    for (int i = 0; i < 400 && rx_q.size() < n; i++) step();
    step();
    step();
    check("fifo_empty_after_drain", out_valid, 0);
  endtask

  task automatic compare_pixels(input int n);
    check("rx_count", rx_q.size(), n);
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      check($sformatf("pixel%0d", i), rx_q[i], exp_q[i]);
  endtask

  task automatic finish_frame(input int ew, input int eh, input int ep);
    wait_done();
    check("done_pulses", done_cnt, 1);
    check("busy_at_done", done_busy, 0);
    check("line_width", done_lw, ew);
    check("frame_height", done_fh, eh);
    drain(ep);
    compare_pixels(ep);
    check("overflow_clear", overflow, 0);
    check("line_width_hold", line_width, ew);
    clear_model();
  endtask

  initial begin
    tbl[0] = '{3, 4, 0, 4, 3, 12};
    tbl[1] = '{1, 8, 1, 4, 1, 4};
    tbl[2] = '{2, 1, 0, 1, 2, 2};
    tbl[3] = '{4, 4, 0, 4, 4, 16};
    tbl[4] = '{1, 16, 0, 16, 1, 16};
    tbl[5] = '{2, 6, 1, 3, 2, 6};

    reset = 1'b1; FVV = 1'b0; LVV = 1'b0; VCE = 1'b0;
    red = 8'd0; green = 8'd0; blue = 8'd0; arm = 1'b0;
    out_ready = 1'b0; rand_ready = 1'b0; exp_sof_pend = 1'b0;
    stall = 1'b0; held = '0; done_lw = '0; done_fh = '0; done_busy = 1'b0;
    clear_model();
    step(); step(); step();
    check("rst_cam_enable", cam_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eol", out_eol, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_line_width", line_width, 0);
    check("rst_frame_height", frame_height, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    step();

    // Table of frame shapes with constant expected geometry and pixel count.
    rand_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      clear_model();
      do_arm();
      drive_frame(tbl[t].lines, tbl[t].cyc, tbl[t].mode, 1'b1);
      finish_frame(tbl[t].ew, tbl[t].eh, tbl[t].ep);
    end

    // Random frames; geometry derived from per-line qualified counts.
    for (int r = 0; r < 8; r++) begin
      int nl, nc, mw, mh;
      nl = int'($urandom_range(1, 4));
      nc = int'($urandom_range(1, 4));
      clear_model();
      do_arm();
      drive_frame(nl, nc, 2, 1'b1);
      mw = 0;
      mh = 0;
      foreach (line_pix[i]) begin
        if (line_pix[i] > 0) begin
          if (mh == 0) mw = line_pix[i];
          mh++;
        end
      end
      finish_frame(mw, mh, exp_q.size());
    end

    // Arm while a frame is in progress: that frame must be skipped.
    clear_model();
    FVV = 1'b1; LVV = 1'b0;
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    exp_sof_pend = 1'b1;
    check("busy_midframe_arm", busy, 1);
    drive_line(4, 0, 1'b0);
    drive_line(4, 0, 1'b0);
    FVV = 1'b0;
    step();
    step();
    check("no_done_skipped", done_cnt, 0);
    drive_frame(2, 3, 0, 1'b1);
    finish_frame(3, 2, 6);

    // Overflow: consumer stalled through a 20-pixel line.
    clear_model();
    rand_ready = 1'b0;
    out_ready = 1'b0;
    do_arm();
    drive_frame(1, 20, 0, 1'b1);
    wait_done();
    check("ovf_done", done_cnt, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_line_width", done_lw, 20);
    check("ovf_frame_height", done_fh, 1);
    check("ovf_valid", out_valid, 1);
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    drain(16);
    compare_pixels(16);
    check("ovf_sticky", overflow, 1);
    clear_model();
    do_arm();
    check("ovf_cleared_by_arm", overflow, 0);
    drive_frame(1, 3, 0, 1'b1);
    finish_frame(3, 1, 3);

    // Reset during line 2 of a capture.
    clear_model();
    do_arm();
    FVV = 1'b1; LVV = 1'b0;
    step();
    drive_line(4, 0, 1'b0);
    LVV = 1'b1; VCE = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_line_width", line_width, 0);
    check("rstmid_frame_height", frame_height, 0);
    reset = 1'b0; FVV = 1'b0; LVV = 1'b0; VCE = 1'b0;
    step();
    check("rstmid_idle", busy, 0);
    clear_model();
    do_arm();
    drive_frame(2, 4, 0, 1'b1);
    finish_frame(4, 2, 8);

`ifdef CAMERALINK_CAPTURE_GEOMETRY_CHECK_EN
    clear_model();
    do_arm();
    check("geom_after_arm", geom_err, 0);
    FVV = 1'b1; LVV = 1'b0;
    step();
    drive_line(4, 0, 1'b1);
    drive_line(4, 0, 1'b1);
    check("geom_after_l2", geom_err, 0);
    drive_line(3, 0, 1'b1);
    check("geom_after_l3", geom_err, 1);
    FVV = 1'b0;
    step();
    finish_frame(4, 3, 11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
